// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU sequencer: op codes, FSM states, error fill pattern
// and the button-priority encoder.
package alu_ctrl_pkg;
  typedef enum logic [2:0] {OP_LO, OP_NO, OP_ADD, OP_SUB, OP_MULT} op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int          NUM_BTN     = 5;
  localparam logic [63:0] ERR_PATTERN = '1;

  // Button lane index equals the op code, so the lowest set lane wins (U > D > L > R > C).
  function automatic op_t pick_op(input logic [NUM_BTN-1:0] req);
    op_t op;
    op = OP_LO;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (req[i]) op = op_t'(3'(i));
    return op;
  endfunction
endpackage

// File: rtl/alu_ctrl_btn_debounce.sv
// One push-button lane: 2-FF synchronizer, stability counter and a one-cycle
// pulse on the accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive synced samples have disagreed with level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/alu_ctrl.sv
// Board-side sequencer for the ALU: debounced buttons -> op request -> start/done
// handshake -> LED. Optional feature macro: ALU_CTRL_AUTO_REFRESH_EN.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int BITS            = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic            CLK,
  input  logic            CPU_RESETN,
  input  logic [BITS-1:0] SW,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  input  logic            BTNC,
  output logic [2:0]      alu_op,
  output logic [BITS-1:0] alu_a,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [BITS-1:0] alu_result,
  output logic [BITS-1:0] LED,
  output logic            busy,
  output logic            err
);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_raw, btn_rise, unused_lvl;
  state_t             state, state_nxt;
  op_t                op_q;
  logic [TW-1:0]      tmo_cnt;
  logic               req, refresh, tmo_last;

  assign btn_raw = {BTNC, BTNR, BTNL, BTND, BTNU};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (CLK),
      .rst_n (CPU_RESETN),
      .btn   (btn_raw[i]),
      .level (unused_lvl[i]),
      .rise  (btn_rise[i])
    );
  end

  assign req      = |btn_rise;
  assign tmo_last = (state == WAIT) && (tmo_cnt == TMO_LAST);
  assign alu_op   = op_q;

`ifdef ALU_CTRL_AUTO_REFRESH_EN
  logic have_op;

  // Re-issue only makes sense once a previous op has defined op_q.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN)                                  have_op <= 1'b0;
    else if (state == WAIT && (alu_done || tmo_last)) have_op <= 1'b1;
  end

  assign refresh = have_op && (SW != alu_a);
`else
  assign refresh = 1'b0;
`endif

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req || refresh) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_done || tmo_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_start = (state == ISSUE);
    busy      = (state != IDLE);
  end

  // Operand/op latch, timeout counter and result capture.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      op_q    <= OP_LO;
      alu_a   <= '0;
      LED     <= '0;
      err     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_q  <= pick_op(btn_rise);
            alu_a <= SW;
          end else if (refresh) begin
            alu_a <= SW;
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (alu_done) begin
            LED <= alu_result;
            err <= 1'b0;
          end else if (tmo_last) begin
            LED <= ERR_PATTERN[BITS-1:0];
            err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural multi-cycle ALU responder.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic        CLK = 1'b0, CPU_RESETN = 1'b0;
  logic [15:0] SW = '0;
  logic        BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0, BTNC = 1'b0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_result, LED;
  logic        alu_start, alu_done, busy, err;

  int tests = 0, fails = 0;

  logic        md_done = 1'b0, inj_done = 1'b0, md_en = 1'b1;
  logic [15:0] md_res = '0, inj_res = '0;
  int          md_lat = 3, md_wait = 0, start_cnt = 0;
  logic [2:0]  last_op = '0;
  logic [15:0] last_a = '0;

  always #5 CLK = ~CLK;

  alu_ctrl #(.BITS(16), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .SW(SW),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .BTNC(BTNC),
    .alu_op(alu_op), .alu_a(alu_a), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .LED(LED), .busy(busy), .err(err)
  );

  assign alu_done   = md_done | inj_done;
  assign alu_result = inj_done ? inj_res : md_res;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a);
    logic [7:0]  x, y;
    logic [15:0] r;
    bit          run;
    x = a[15:8]; y = a[7:0]; r = '0; run = 1'b1;
    case (op)
      3'd0: for (int i = 15; i >= 0; i--) if (run && a[i]) r++; else run = 1'b0;
      3'd1: r = 16'($countones(a));
      3'd2: r = {8'd0, x} + {8'd0, y};
      3'd3: r = {8'd0, x} - {8'd0, y};
      3'd4: r = {8'd0, x} * {8'd0, y};
      default: r = '0;
    endcase
    return r;
  endfunction

  // ALU responder: done md_lat cycles after the start cycle, result from the latched operand.
  always @(negedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      md_done = 1'b0;
      md_wait = 0;
    end else begin
      md_done = 1'b0;
      if (alu_start) begin
        start_cnt++;
        last_op = alu_op;
        last_a  = alu_a;
        if (md_en) md_wait = md_lat;
      end else if (md_wait > 0) begin
        md_wait--;
        if (md_wait == 0) begin
          md_done = 1'b1;
          md_res  = alu_fn(alu_op, alu_a);
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic do_reset();
    CPU_RESETN = 1'b0;
    {BTNU, BTND, BTNL, BTNR, BTNC} = '0;
    inj_done = 1'b0; md_en = 1'b1; md_lat = 3;
    repeat (3) tick();
    CPU_RESETN = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_start(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (start_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    CPU_RESETN = 1'b0;
    tick();
    tests++; if (LED !== 16'h0000) begin fails++; $display("FAIL rst_led: got %h exp 0000", LED); end
    tests++; if (alu_a !== 16'h0000) begin fails++; $display("FAIL rst_alu_a: got %h exp 0000", alu_a); end
    tests++; if (alu_op !== 3'd0) begin fails++; $display("FAIL rst_alu_op: got %0d exp 0", alu_op); end
    tests++; if (alu_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b exp 0", alu_start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", err); end
  endtask

  task automatic test_add();
    int  base, start_i;
    bit  seen;
    do_reset();
    SW = 16'h0305; base = start_cnt; start_i = -1; seen = 1'b0;
    BTNL = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (i == 20) BTNL = 1'b0;
      tick();
      if (start_i < 0 && start_cnt > base) begin
        start_i = i;
        SW = 16'h1111;
      end
      if (alu_done) begin
        seen = 1'b1;
        tests++; if (LED !== 16'h0000) begin fails++; $display("FAIL add_led_early: got %h exp 0000", LED); end
        SW = 16'h0305;
        tick();
        tests++; if (LED !== 16'h0008) begin fails++; $display("FAIL add_led: got %h exp 0008", LED); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL add_err: got %b exp 0", err); end
      end
    end
    BTNL = 1'b0;
    tests++; if (!seen) begin fails++; $display("FAIL add_done_timeout: got no done exp done"); end
    tests++; if (start_i !== 18) begin fails++; $display("FAIL add_start_latency: got %0d exp 18", start_i); end
    repeat (40) tick();
    tests++; if (start_cnt - base !== 1) begin fails++; $display("FAIL add_start_count: got %0d exp 1", start_cnt - base); end
    tests++; if (last_op !== 3'd2) begin fails++; $display("FAIL add_op: got %0d exp 2", last_op); end
    tests++; if (last_a !== 16'h0305) begin fails++; $display("FAIL add_alu_a: got %h exp 0305", last_a); end
  endtask

  task automatic test_bounce();
    int base;
    do_reset();
    SW = 16'h0304; base = start_cnt;
    for (int k = 0; k < 12; k++) begin
      BTNC = ((k / 3) % 2) == 0;
      tick();
    end
    BTNC = 1'b1;
    repeat (25) tick();
    BTNC = 1'b0;
    repeat (40) tick();
    tests++; if (start_cnt - base !== 1) begin fails++; $display("FAIL bounce_start_count: got %0d exp 1", start_cnt - base); end
    tests++; if (last_op !== 3'd4) begin fails++; $display("FAIL bounce_op: got %0d exp 4", last_op); end
    tests++; if (LED !== 16'h000C) begin fails++; $display("FAIL bounce_led: got %h exp 000c", LED); end
  endtask

  task automatic test_priority();
    int base;
    do_reset();
    SW = 16'hF0F0; base = start_cnt;
    BTNU = 1'b1; BTNR = 1'b1;
    repeat (25) tick();
    BTNU = 1'b0; BTNR = 1'b0;
    repeat (40) tick();
    tests++; if (start_cnt - base !== 1) begin fails++; $display("FAIL prio_start_count: got %0d exp 1", start_cnt - base); end
    tests++; if (last_op !== 3'd0) begin fails++; $display("FAIL prio_op: got %0d exp 0", last_op); end
    tests++; if (LED !== 16'h0004) begin fails++; $display("FAIL prio_led: got %h exp 0004", LED); end
  endtask

  task automatic test_timeout();
    int base, busy_n;
    bit ok;
    do_reset();
    md_en = 1'b0; SW = 16'h0102; base = start_cnt;
    BTND = 1'b1;
    wait_start(base, ok);
    BTND = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL tmo_start_timeout: got no start exp start"); end
    busy_n = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy) break;
      busy_n++;
    end
    tests++; if (busy_n !== 65) begin fails++; $display("FAIL tmo_busy_cycles: got %0d exp 65", busy_n); end
    tests++; if (LED !== 16'hFFFF) begin fails++; $display("FAIL tmo_led: got %h exp ffff", LED); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b exp 1", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_busy: got %b exp 0", busy); end
    md_en = 1'b1;
    repeat (20) tick();
    BTNL = 1'b1;
    repeat (25) tick();
    BTNL = 1'b0;
    repeat (40) tick();
    tests++; if (start_cnt - base !== 2) begin fails++; $display("FAIL tmo_retry_count: got %0d exp 2", start_cnt - base); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL tmo_err_clear: got %b exp 0", err); end
    tests++; if (LED !== 16'h0003) begin fails++; $display("FAIL tmo_retry_led: got %h exp 0003", LED); end
  endtask

  task automatic test_drop();
    int base;
    bit ok;
    do_reset();
    md_lat = 30; SW = 16'h0203; base = start_cnt;
    BTNL = 1'b1;
    wait_start(base, ok);
    BTNL = 1'b0; BTND = 1'b1;
    repeat (25) tick();
    BTND = 1'b0;
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL drop_idle_timeout: got busy exp idle"); end
    repeat (20) tick();
    inj_res = 16'hBEEF; inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    tests++; if (start_cnt - base !== 1) begin fails++; $display("FAIL drop_start_count: got %0d exp 1", start_cnt - base); end
    tests++; if (LED !== 16'h0005) begin fails++; $display("FAIL drop_led: got %h exp 0005", LED); end
    base = start_cnt;
    BTNL = 1'b1;
    wait_start(base, ok);
    BTNL = 1'b0;
    repeat (5) tick();
    CPU_RESETN = 1'b0;
    #1;
    tests++; if (LED !== 16'h0000) begin fails++; $display("FAIL midrst_led: got %h exp 0000", LED); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    tick();
    CPU_RESETN = 1'b1;
    repeat (60) tick();
    tests++; if (start_cnt - base !== 1) begin fails++; $display("FAIL midrst_replay: got %0d exp 1", start_cnt - base); end
    tests++; if (LED !== 16'h0000) begin fails++; $display("FAIL midrst_led_after: got %h exp 0000", LED); end
  endtask

  task automatic test_autorefresh();
    int base;
    do_reset();
    SW = 16'h0A03;
    BTNR = 1'b1;
    repeat (25) tick();
    BTNR = 1'b0;
    repeat (40) tick();
    tests++; if (LED !== 16'h0007) begin fails++; $display("FAIL ar_first_led: got %h exp 0007", LED); end
    base = start_cnt;
    SW = 16'h0A01;
    repeat (40) tick();
`ifdef ALU_CTRL_AUTO_REFRESH_EN
    tests++; if (start_cnt - base !== 1) begin fails++; $display("FAIL ar_reissue_count: got %0d exp 1", start_cnt - base); end
    tests++; if (last_a !== 16'h0A01) begin fails++; $display("FAIL ar_alu_a: got %h exp 0a01", last_a); end
    tests++; if (last_op !== 3'd3) begin fails++; $display("FAIL ar_op: got %0d exp 3", last_op); end
    tests++; if (LED !== 16'h0009) begin fails++; $display("FAIL ar_led: got %h exp 0009", LED); end
`else
    tests++; if (start_cnt - base !== 0) begin fails++; $display("FAIL ar_no_reissue: got %0d exp 0", start_cnt - base); end
    tests++; if (LED !== 16'h0007) begin fails++; $display("FAIL ar_led_hold: got %h exp 0007", LED); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_bounce();
    test_priority();
    test_timeout();
    test_drop();
    test_autorefresh();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog expired");
  end
endmodule
